// File: rtl/m_xor_serial_seq_pkg.sv
// Shared constants for the serial XOR sequencer: FSM encodings and the
// parity accumulation step.
package m_xor_serial_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic f_par_step(input logic acc, input logic bit_v);
    return acc ^ bit_v;
  endfunction

endpackage

// File: rtl/m_xor_serial_seq_xor.sv
// Single-bit XOR cell; the one shared resource the sequencer time-multiplexes.
module m_xor (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/m_xor_serial_seq.sv
// Bit-serial A XOR B engine: one bit pair per cycle through a shared m_xor,
// with a valid/ready request side and a valid/ready result side.
module m_xor_serial_seq
  import m_xor_serial_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_abort,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_parity,
  output logic             o_busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_r, state_nx_s;
  logic [WIDTH-1:0] a_r, a_nx_s;
  logic [WIDTH-1:0] b_r, b_nx_s;
  logic [WIDTH-1:0] res_r, res_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic             par_r, par_nx_s;
  logic             bit_s;
  logic             ready_r, valid_r, busy_r, par_out_r;
  logic [WIDTH-1:0] result_out_r;

  m_xor u_xor (
    .a (a_r[0]),
    .b (b_r[0]),
    .y (bit_s)
  );

  // Next-state, datapath and abort-override logic
  always_comb begin
    state_nx_s = state_r;
    a_nx_s     = a_r;
    b_nx_s     = b_r;
    res_nx_s   = res_r;
    cnt_nx_s   = cnt_r;
    par_nx_s   = par_r;
    case (state_r)
      ST_IDLE: begin
        // ready_r is low for one cycle after reset release, so it gates acceptance
        if (i_valid && ready_r) begin
          a_nx_s     = i_a;
          b_nx_s     = i_b;
          res_nx_s   = {WIDTH{1'b0}};
          cnt_nx_s   = {CNT_W{1'b0}};
          par_nx_s   = 1'b0;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_nx_s   = {1'b0, a_r[WIDTH-1:1]};
        b_nx_s   = {1'b0, b_r[WIDTH-1:1]};
        res_nx_s = {bit_s, res_r[WIDTH-1:1]};
        par_nx_s = f_par_step(par_r, bit_s);
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_nx_s = ST_DONE;
        end else begin
          cnt_nx_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    if (i_abort) begin
      state_nx_s = ST_IDLE;
      res_nx_s   = {WIDTH{1'b0}};
      par_nx_s   = 1'b0;
      cnt_nx_s   = {CNT_W{1'b0}};
    end else begin
      state_nx_s = state_nx_s;
    end
  end

  // State, datapath and registered outputs decoded from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      res_r        <= {WIDTH{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      par_r        <= 1'b0;
      ready_r      <= 1'b0;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      result_out_r <= {WIDTH{1'b0}};
      par_out_r    <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      a_r          <= a_nx_s;
      b_r          <= b_nx_s;
      res_r        <= res_nx_s;
      cnt_r        <= cnt_nx_s;
      par_r        <= par_nx_s;
      ready_r      <= (state_nx_s == ST_IDLE);
      valid_r      <= (state_nx_s == ST_DONE);
      busy_r       <= (state_nx_s != ST_IDLE);
      result_out_r <= (state_nx_s == ST_DONE) ? res_nx_s : {WIDTH{1'b0}};
      par_out_r    <= (state_nx_s == ST_DONE) ? par_nx_s : 1'b0;
    end
  end

  assign o_ready  = ready_r;
  assign o_valid  = valid_r;
  assign o_busy   = busy_r;
  assign o_result = result_out_r;
  assign o_parity = par_out_r;

endmodule

// File: tb/tb_m_xor_serial_seq.sv
// Directed bench for m_xor_serial_seq: latency, hold under back-pressure,
// abort, mid-job reset and back-to-back streaming.
module tb_m_xor_serial_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_abort, i_ready;
  logic [15:0] a, b;
  logic        o_ready, o_valid, o_parity, o_busy;
  logic [15:0] o_result;

  int checks = 0;
  int errors = 0;
  int n, seen, v1, i1, a2, v2;
  logic [15:0] r, r1, r2;
  logic        p, p1, p2;

  always #5 clk = ~clk;

  m_xor_serial_seq #(.WIDTH(16)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (a),
    .i_b      (b),
    .i_abort  (i_abort),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_parity (o_parity),
    .o_busy   (o_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    a = 16'h0000; b = 16'h0000;
    #1;
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_result", o_result, 0);
    chk("rst_parity", o_parity, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_ready_pre", o_ready, 0);
    @(posedge clk); #1;
    chk("rel_ready_post", o_ready, 1);

    // FFFF ^ 0F0F
    @(negedge clk); a = 16'hFFFF; b = 16'h0F0F; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    chk("t1_busy", o_busy, 1);
    chk("t1_result_run", o_result, 0);
    n = 0;
    while (!o_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("t1_latency", n, 16);
    chk("t1_result", o_result, 16'hF0F0);
    chk("t1_parity", o_parity, 0);
    @(posedge clk); #1;
    chk("t1_valid_drop", o_valid, 0);
    chk("t1_ready_back", o_ready, 1);

    // 0001 ^ 0000, count ready-low cycles
    @(negedge clk); a = 16'h0001; b = 16'h0000; i_valid = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    n = 0; r = 16'h0000; p = 1'b0;
    while (!o_ready && n < 40) begin
      n++;
      if (o_valid) begin r = o_result; p = o_parity; end
      @(posedge clk); #1;
    end
    chk("t2_ready_low", n, 17);
    chk("t2_result", r, 16'h0001);
    chk("t2_parity", p, 1);

    // back-pressure in DONE: 00F0 ^ 0E00 = 0EF0, 7 ones
    @(negedge clk); a = 16'h00F0; b = 16'h0E00; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge clk); #1; i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("t3_latency", n, 16);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); i_valid = 1'b1; a = 16'h1111 + 16'(k); b = 16'hFFFF;
      @(posedge clk); #1; i_valid = 1'b0;
      chk("t3_hold_valid", o_valid, 1);
      chk("t3_hold_ready", o_ready, 0);
      chk("t3_hold_result", o_result, 16'h0EF0);
      chk("t3_hold_parity", o_parity, 1);
    end
    @(negedge clk); i_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_valid", o_valid, 0);
    chk("t3_release_busy", o_busy, 0);
    chk("t3_release_ready", o_ready, 1);
    @(posedge clk); #1;
    chk("t3_no_queued_job", o_busy, 0);

    // abort at RUN cycle 7 with a competing request
    @(negedge clk); a = 16'hFFFF; b = 16'h0000; i_valid = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); i_abort = 1'b1; i_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
    @(posedge clk); #1; i_abort = 1'b0;
    chk("t4_abort_busy", o_busy, 0);
    chk("t4_abort_valid", o_valid, 0);
    chk("t4_abort_ready", o_ready, 1);
    @(posedge clk); #1; i_valid = 1'b0;
    chk("t4_accept_busy", o_busy, 1);
    n = 0;
    while (!o_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("t4_latency", n, 16);
    chk("t4_result", o_result, 16'hFFFF);
    chk("t4_parity", o_parity, 0);
    @(posedge clk); #1;

    // reset asserted between edges mid-RUN
    @(negedge clk); a = 16'h1234; b = 16'h0000; i_valid = 1'b1;
    @(posedge clk); #1; i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("t5_rst_ready", o_ready, 0);
    chk("t5_rst_valid", o_valid, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_result", o_result, 0);
    chk("t5_rst_parity", o_parity, 0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (o_valid || o_busy) seen++;
    end
    chk("t5_no_stale", seen, 0);
    chk("t5_ready", o_ready, 1);

    // streaming with i_valid and i_ready held high
    @(negedge clk); a = 16'h1234; b = 16'h00FF; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1; a = 16'h8000; b = 16'h0000;
    v1 = -1; i1 = -1; a2 = -1; v2 = -1;
    r1 = 16'h0000; p1 = 1'b0; r2 = 16'h0000; p2 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (o_valid && v1 < 0) begin v1 = k; r1 = o_result; p1 = o_parity; end
      if (v1 >= 0 && i1 < 0 && !o_busy) i1 = k;
      if (i1 >= 0 && a2 < 0 && o_busy) a2 = k;
      if (a2 >= 0 && v2 < 0 && o_valid) begin v2 = k; r2 = o_result; p2 = o_parity; end
    end
    i_valid = 1'b0;
    chk("t6_v1", v1, 16);
    chk("t6_r1", r1, 16'h12CB);
    chk("t6_p1", p1, 1);
    chk("t6_idle", i1, 17);
    chk("t6_accept2", a2, 18);
    chk("t6_v2", v2, 34);
    chk("t6_r2", r2, 16'h8000);
    chk("t6_p2", p2, 1);
    @(negedge clk); i_abort = 1'b1;
    @(posedge clk); #1; i_abort = 1'b0;
    chk("t6_end_busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_xor_serial_seq.md
M_XOR_SERIAL_SEQ -- requirements
Module: m_xor_serial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_valid  input  1  request: operands on i_a/i_b are valid.
REQ-005 SHALL have port o_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port i_a  input  WIDTH  operand A.
REQ-007 SHALL have port i_b  input  WIDTH  operand B.
REQ-008 SHALL have port i_abort  input  1  synchronous cancel of any in-flight job.
REQ-009 SHALL have port o_valid  output  1  o_result/o_parity hold a completed job.
REQ-010 SHALL have port i_ready  input  1  consumer accepts the result this cycle.
REQ-011 SHALL have port o_result  output  WIDTH  bitwise A XOR B.
REQ-012 SHALL have port o_parity  output  1  XOR-reduction of o_result (1 = odd count of ones).
REQ-013 SHALL have port o_busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; o_ready = (state==IDLE), o_valid = (state==DONE), o_busy = (state!=IDLE).
REQ-015 SHALL accept a job on a rising edge where i_valid && o_ready && !i_abort: latch i_a, i_b into shift registers, clear bit counter, parity accumulator and result register, go to RUN.
REQ-016 SHALL, in RUN, evaluate exactly one bit pair per cycle, LSB first, through one shared m_xor instance; result bit shifts in at the MSB of the result register, parity accumulator XORs in the same bit.
REQ-017 SHALL use a bit counter of clog2(WIDTH) bits; transition RUN->DONE on the edge that processes bit WIDTH-1, with no counter wrap observable.
REQ-018 SHALL have latency: job accepted at edge t, o_valid high in the cycle after edge t+WIDTH (16 cycles for default).
REQ-019 SHALL, in DONE, hold o_result and o_parity stable until the edge where i_ready is high, then return to IDLE.
REQ-020 SHALL ignore i_valid whenever o_ready is low; operands are never re-sampled mid-job.
REQ-021 SHALL have no combinational path from i_ready to o_ready; minimum one IDLE cycle between consecutive jobs.
REQ-022 SHALL give i_abort priority over every other event: on any edge with i_abort high, go to IDLE, clear result, parity and counter; a same-edge i_valid is not accepted.
REQ-023 SHALL drive o_result and o_parity as zero in IDLE and RUN; only DONE exposes the computed values.

Reset
REQ-024 SHALL, while i_rst_n is low, force state IDLE, counter 0, shift/result registers 0, o_valid 0, o_result 0, o_parity 0, o_busy 0, independent of i_clk.
REQ-025 SHALL force o_ready 0 while i_rst_n is low; o_ready rises in the first cycle after deassertion.
REQ-026 SHALL discard any in-flight job when reset asserts mid-RUN or in DONE, with no result emitted after release.

Structure
REQ-027 SHALL take state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) from the shared CPU constants package; WIDTH stays a local parameter.
REQ-028 SHALL contain exactly one sub-module instance, m_xor, as the serialized shared resource; no other XOR of operand bits is permitted.

Verification
REQ-029 SHALL cover: a=16'hFFFF, b=16'h0F0F, i_ready=1 -> o_valid after 16 cycles, o_result=16'hF0F0, o_parity=0.
REQ-030 SHALL cover: a=16'h0001, b=16'h0000 -> o_result=16'h0001, o_parity=1; o_ready low for exactly 17 cycles.
REQ-031 SHALL cover: i_ready held low 5 cycles in DONE -> o_result/o_parity constant, o_ready=0, i_valid pulses ignored; i_ready=1 -> IDLE next edge.
REQ-032 SHALL cover: abort at RUN cycle 7 with i_valid high -> IDLE next edge, no o_valid, job not accepted; then a=16'hAAAA, b=16'h5555 -> 16'hFFFF, parity 0.
REQ-033 SHALL cover: i_rst_n low mid-RUN (between edges) -> all outputs at reset values immediately; after release no stale o_valid.
REQ-034 SHALL cover: i_valid and i_ready held high, jobs 16'h1234^16'h00FF then 16'h8000^16'h0000 -> results 16'h12CB (parity 1), 16'h8000 (parity 1), second accepted one cycle after first consumed.
